noc_output_vc_scheduler: RTL and testbench
==========================================

# noc_output_vc_scheduler

Per-output-port flit scheduler for the router switch stage. It shares one physical output link among CHANNELS virtual channels by issuing at most one flit pop per cycle, round-robin among eligible VCs. Eligibility is gated by per-VC downstream credit counters and per-VC packet state. It sits between the per-VC input FIFOs already granted to this output and the output link register, and supplies the credit/lock view that the port controllers use for VC arbitration.

## Interface
- CHANNELS, default 2 (Noc_VC_Channel), number of virtual channels, 1..8
- CREDIT_DEPTH, default 4, downstream per-VC buffer depth; the reset value of every credit counter
- CREDIT_W, default $clog2(CREDIT_DEPTH+1), derived, not overridden

- noc_clk  in  1  clock; the block uses only this clock
- noc_rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of noc_clk
- flit_valid_i  in  CHANNELS  VC i has a flit at its FIFO head
- flit_head_i  in  CHANNELS  head-flit marker for VC i's current flit
- flit_tail_i  in  CHANNELS  tail-flit marker; a single-flit packet has head=tail=1
- flit_pop_o  out  CHANNELS  combinational, one-hot or zero; consumes VC i's head flit this cycle
- link_valid_o  out  1  registered; a flit is on the link this cycle
- link_vc_o  out  CHANNELS  registered one-hot VC tag of the link flit
- credit_return_i  in  CHANNELS  downstream freed one slot of VC i
- credit_o  out  CHANNELS*CREDIT_W  current credit count per VC; VC i occupies bits [i*CREDIT_W +: CREDIT_W]
- busy_o  out  CHANNELS  registered; VC i is mid-packet (ACTIVE)
- err_o  out  1  sticky protocol-error flag

## Operation
- Per-VC state machine with two states:
  - IDLE -> ACTIVE on a popped head flit with tail=0.
  - ACTIVE -> IDLE on a popped tail flit.
  - A head+tail flit popped in IDLE stays in IDLE.
- Eligibility of VC i: flit_valid_i[i] & credit[i]!=0 & (ACTIVE | flit_head_i[i]).
- Protocol errors:
  - A valid non-head flit in IDLE is never popped and sets err_o.
  - A valid head flit in ACTIVE is popped as body and sets err_o; the state machine treats it as body.
- Round-robin arbitration:
  - Pointer ptr, range 0..CHANNELS-1, reset 0.
  - Search order is ptr, ptr+1, …, wrapping modulo CHANNELS; CHANNELS need not be a power of two.
  - The first eligible VC k wins, and ptr is set to (k+1) mod CHANNELS.
  - With no winner, ptr holds.
- Credit counter per VC:
  - Pop only: -1.
  - Return only: +1.
  - Pop and return in the same cycle: unchanged.
  - A return while the counter equals CREDIT_DEPTH with no pop leaves the counter unchanged and sets err_o.
  - A pop never occurs at 0 because eligibility requires credit.
- With CHANNELS=1: the arbiter degenerates to the eligibility bit and ptr is constant 0.
- err_o is cleared only by reset.

## Timing
- Reset values:
  - flit_pop_o=0, link_valid_o=0, link_vc_o=0, busy_o=0, err_o=0.
  - Every credit = CREDIT_DEPTH, all VCs IDLE, ptr=0.
- Reset asserted mid-packet: all state returns to reset values on the next edge with no pop that cycle. The flushed VCs restart in IDLE and require a head flit.
- flit_pop_o is combinational from the inputs and registered state, with zero latency.
- In the cycle after a pop of VC k:
  - link_valid_o=1 and link_vc_o=1<<k.
  - credit_o and busy_o reflect the pop.
- credit_return_i affects eligibility starting the cycle after it is asserted; there is no combinational credit bypass.
- Throughput is one flit per cycle when any VC is eligible.

## Configuration
- NOC_VC_SCHED_PKT_LOCK_EN defined:
  - When a VC pops a head with tail=0, the link locks to that VC.
  - Only that VC is eligible until its tail pops, so there is no flit interleaving.
  - The round-robin pointer is frozen while locked and advances normally on the tail pop.
  - If the locked VC lacks flits or credit, the link idles.
- NOC_VC_SCHED_PKT_LOCK_EN undefined: flits of different VCs interleave cycle by cycle under round-robin, as described in Operation.

## Test plan
- Reset, CHANNELS=2, CREDIT_DEPTH=4, idle inputs -> credit_o = {4,4}, all outputs 0, no pops.
- Both VCs continuously valid with 3-flit packets, no credit returns, lock macro undefined:
  - Pops alternate VC0, VC1, VC0, VC1, …
  - Each VC stops after 4 pops, and credit_o = {0,0}.
  - link_vc_o trails flit_pop_o by exactly 1 cycle.
- VC0 at credit 0 with a flit valid, then credit_return_i[0] pulsed for 1 cycle:
  - No pop in the return cycle.
  - VC0 pops the next cycle, and credit[0] returns to 0 afterwards.
- Simultaneous pop and credit return on VC1 at credit 2 -> credit stays 2. A return at credit 4 with no pop -> stays 4 and err_o=1, held until reset.
- Body flit (head=0) presented on IDLE VC0 -> never popped, err_o=1. A noc_rst_n pulse mid-packet -> busy_o=0 and credits back at 4 on the next cycle.
- NOC_VC_SCHED_PKT_LOCK_EN defined, VC0 4-flit packet with VC1 valid throughout -> four consecutive VC0 pops, then VC1's head flit pops on the next cycle.

Source files
------------

// File: rtl/noc_output_vc_scheduler_if.sv
// noc_output_vc_scheduler_if: flit/link/credit bundle between VC FIFOs, scheduler and port controllers
// Parameters: CHANNELS (VC count), CREDIT_W (credit counter width)
// master: upstream side; drives flit_valid/head/tail and credit_return, observes the rest
// slave:  scheduler side; drives flit_pop, link_valid/link_vc, credit, busy, err
interface noc_output_vc_scheduler_if #(
  parameter int CHANNELS = 2,
  parameter int CREDIT_W = 3
);
  logic [CHANNELS-1:0]          flit_valid_i;
  logic [CHANNELS-1:0]          flit_head_i;
  logic [CHANNELS-1:0]          flit_tail_i;
  logic [CHANNELS-1:0]          flit_pop_o;
  logic                         link_valid_o;
  logic [CHANNELS-1:0]          link_vc_o;
  logic [CHANNELS-1:0]          credit_return_i;
  logic [CHANNELS*CREDIT_W-1:0] credit_o;
  logic [CHANNELS-1:0]          busy_o;
  logic                         err_o;
  modport master (
    output flit_valid_i, flit_head_i, flit_tail_i, credit_return_i,
    input  flit_pop_o, link_valid_o, link_vc_o, credit_o, busy_o, err_o
  );
  modport slave (
    input  flit_valid_i, flit_head_i, flit_tail_i, credit_return_i,
    output flit_pop_o, link_valid_o, link_vc_o, credit_o, busy_o, err_o
  );
endinterface

// File: rtl/noc_output_vc_scheduler.sv
// noc_output_vc_scheduler: round-robin, credit-gated flit scheduler sharing one output link among VCs
// Ports: noc_clk (clock), noc_rst_n (sync active-low reset), bus (slave modport of
//   noc_output_vc_scheduler_if: flit valid/head/tail in, pop out, link valid/vc out,
//   credit return in, credit/busy/err out)
// Option: NOC_VC_SCHED_PKT_LOCK_EN locks the link to one VC from head to tail flit
module noc_output_vc_scheduler #(
  parameter int CHANNELS     = 2,
  parameter int CREDIT_DEPTH = 4
) (
  input logic                        noc_clk,
  input logic                        noc_rst_n,
  noc_output_vc_scheduler_if.slave   bus
);
  localparam int CREDIT_W = $clog2(CREDIT_DEPTH + 1);
  localparam int PTR_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  localparam logic [CREDIT_W-1:0] FULL = CREDIT_W'(CREDIT_DEPTH);
  logic [CHANNELS-1:0] active_q, active_d, elig, pop, link_vc_q;
  logic [CREDIT_W-1:0] credit_q [CHANNELS];
  logic [CREDIT_W-1:0] credit_d [CHANNELS];
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic                link_valid_q, err_q, err_d;
  always_comb begin
    for (int i = 0; i < CHANNELS; i++)
      elig[i] = bus.flit_valid_i[i] & (credit_q[i] != '0) & (active_q[i] | bus.flit_head_i[i]);
`ifdef NOC_VC_SCHED_PKT_LOCK_EN
    // a mid-packet VC owns the link exclusively until its tail leaves
    if (|active_q) elig = elig & active_q;
`endif
  end
  // search from ptr upward with explicit wrap so CHANNELS need not be a power of two
  always_comb begin
    pop = '0;
    ptr_d = ptr_q;
    for (int j = 0; j < CHANNELS; j++) begin
      int k;
      k = int'(ptr_q) + j;
      if (k >= CHANNELS) k -= CHANNELS;
      if (pop == '0 && elig[k] && noc_rst_n) begin
        pop[k] = 1'b1;
        ptr_d = (k + 1 == CHANNELS) ? '0 : PTR_W'(k + 1);
      end
    end
`ifdef NOC_VC_SCHED_PKT_LOCK_EN
    if (|active_q && !(|(pop & bus.flit_tail_i))) ptr_d = ptr_q;
`endif
  end
  always_ff @(posedge noc_clk) begin
    if (!noc_rst_n) active_q <= '0;
    else active_q <= active_d;
  end
  // a head popped while ACTIVE is treated as body, so only the tail bit decides the next state
  always_comb begin
    for (int i = 0; i < CHANNELS; i++)
      active_d[i] = pop[i] ? ~bus.flit_tail_i[i] : active_q[i];
  end
  assign bus.flit_pop_o = pop;
  assign bus.busy_o = active_q;
  always_comb begin
    err_d = err_q;
    for (int i = 0; i < CHANNELS; i++) begin
      credit_d[i] = (pop[i] & ~bus.credit_return_i[i]) ? credit_q[i] - 1'b1 :
                    (bus.credit_return_i[i] & ~pop[i] & credit_q[i] != FULL) ? credit_q[i] + 1'b1 :
                    credit_q[i];
      err_d |= bus.credit_return_i[i] & ~pop[i] & (credit_q[i] == FULL);
      err_d |= bus.flit_valid_i[i] & ~bus.flit_head_i[i] & ~active_q[i];
      err_d |= pop[i] & bus.flit_head_i[i] & active_q[i];
    end
  end
  always_ff @(posedge noc_clk) begin
    if (!noc_rst_n) begin
      ptr_q <= '0;
      link_valid_q <= 1'b0;
      link_vc_q <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) credit_q[i] <= FULL;
    end else begin
      ptr_q <= ptr_d;
      link_valid_q <= |pop;
      link_vc_q <= pop;
      err_q <= err_d;
      for (int i = 0; i < CHANNELS; i++) credit_q[i] <= credit_d[i];
    end
  end
  for (genvar g = 0; g < CHANNELS; g++) begin : g_credit
    assign bus.credit_o[g*CREDIT_W +: CREDIT_W] = credit_q[g];
  end
  assign bus.link_valid_o = link_valid_q;
  assign bus.link_vc_o = link_vc_q;
  assign bus.err_o = err_q;
endmodule

// File: tb/tb_noc_output_vc_scheduler.sv
// tb_noc_output_vc_scheduler: directed self-checking bench, CHANNELS=2, CREDIT_DEPTH=4
module tb_noc_output_vc_scheduler;
  logic clk;
  logic rst_n;
  int checks;
  int fails;
  noc_output_vc_scheduler_if #(.CHANNELS(2), .CREDIT_W(3)) bus ();
  noc_output_vc_scheduler #(.CHANNELS(2), .CREDIT_DEPTH(4)) dut (
    .noc_clk(clk),
    .noc_rst_n(rst_n),
    .bus(bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [1:0] exp;
    int i0;
    int i1;
    checks = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.flit_valid_i = '0;
    bus.flit_head_i = '0;
    bus.flit_tail_i = '0;
    bus.credit_return_i = '0;
    tick();
    tick();
    chk("rst_pop", 32'(bus.flit_pop_o), 32'(2'b00));
    rst_n = 1'b1;
    tick();
    chk("rst_credit", 32'(bus.credit_o), 32'(6'b100_100));
    chk("rst_link_valid", 32'(bus.link_valid_o), 32'(1'b0));
    chk("rst_link_vc", 32'(bus.link_vc_o), 32'(2'b00));
    chk("rst_busy", 32'(bus.busy_o), 32'(2'b00));
    chk("rst_err", 32'(bus.err_o), 32'(1'b0));
    chk("rst_idle_pop", 32'(bus.flit_pop_o), 32'(2'b00));
`ifndef NOC_VC_SCHED_PKT_LOCK_EN
    i0 = 0;
    i1 = 0;
    for (int c = 0; c < 10; c++) begin
      bus.flit_valid_i = 2'b11;
      bus.flit_head_i = {i1 == 0, i0 == 0};
      bus.flit_tail_i = {i1 == 2, i0 == 2};
      #1;
      exp = c < 8 ? (c % 2 == 0 ? 2'b01 : 2'b10) : 2'b00;
      chk("rr_pop", 32'(bus.flit_pop_o), 32'(exp));
      tick();
      chk("rr_link_vc", 32'(bus.link_vc_o), 32'(exp));
      chk("rr_link_valid", 32'(bus.link_valid_o), 32'(|exp));
      if (exp[0]) i0 = (i0 + 1) % 3;
      if (exp[1]) i1 = (i1 + 1) % 3;
    end
    chk("rr_credit", 32'(bus.credit_o), 32'(6'b000_000));
    chk("rr_busy", 32'(bus.busy_o), 32'(2'b11));
    chk("rr_err", 32'(bus.err_o), 32'(1'b0));
    bus.flit_valid_i = 2'b01;
    bus.flit_head_i = 2'b00;
    bus.flit_tail_i = 2'b00;
    bus.credit_return_i = 2'b01;
    #1;
    chk("ret_cycle_pop", 32'(bus.flit_pop_o), 32'(2'b00));
    tick();
    bus.credit_return_i = 2'b00;
    #1;
    chk("ret_next_pop", 32'(bus.flit_pop_o), 32'(2'b01));
    tick();
    chk("ret_credit0", 32'(bus.credit_o[2:0]), 32'(3'd0));
    chk("ret_link_vc", 32'(bus.link_vc_o), 32'(2'b01));
    bus.flit_valid_i = 2'b00;
    bus.credit_return_i = 2'b10;
    tick();
    tick();
    chk("vc1_credit2", 32'(bus.credit_o[5:3]), 32'(3'd2));
    bus.flit_valid_i = 2'b10;
    #1;
    chk("popret_pop", 32'(bus.flit_pop_o), 32'(2'b10));
    tick();
    chk("popret_credit", 32'(bus.credit_o[5:3]), 32'(3'd2));
    bus.flit_valid_i = 2'b00;
    bus.credit_return_i = 2'b01;
    for (int c = 0; c < 4; c++) tick();
    chk("vc0_full", 32'(bus.credit_o[2:0]), 32'(3'd4));
    chk("err_before_over", 32'(bus.err_o), 32'(1'b0));
    tick();
    chk("over_credit", 32'(bus.credit_o[2:0]), 32'(3'd4));
    chk("over_err", 32'(bus.err_o), 32'(1'b1));
    bus.credit_return_i = 2'b00;
    tick();
    tick();
    chk("err_sticky", 32'(bus.err_o), 32'(1'b1));
    chk("mid_busy", 32'(bus.busy_o), 32'(2'b11));
    bus.flit_valid_i = 2'b10;
    bus.flit_tail_i = 2'b10;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_pop", 32'(bus.flit_pop_o), 32'(2'b00));
    tick();
    rst_n = 1'b1;
    bus.flit_valid_i = 2'b00;
    bus.flit_tail_i = 2'b00;
    chk("flush_busy", 32'(bus.busy_o), 32'(2'b00));
    chk("flush_credit", 32'(bus.credit_o), 32'(6'b100_100));
    chk("flush_err", 32'(bus.err_o), 32'(1'b0));
    chk("flush_link", 32'(bus.link_valid_o), 32'(1'b0));
    bus.flit_valid_i = 2'b01;
    #1;
    chk("body_idle_pop", 32'(bus.flit_pop_o), 32'(2'b00));
    tick();
    chk("body_idle_err", 32'(bus.err_o), 32'(1'b1));
    chk("body_idle_pop2", 32'(bus.flit_pop_o), 32'(2'b00));
    chk("body_idle_busy", 32'(bus.busy_o), 32'(2'b00));
    bus.flit_valid_i = 2'b00;
`else
    i0 = 0;
    for (int c = 0; c < 6; c++) begin
      bus.flit_valid_i = {1'b1, i0 < 4};
      bus.flit_head_i = {1'b1, i0 == 0};
      bus.flit_tail_i = {1'b1, i0 == 3};
      #1;
      exp = c < 4 ? 2'b01 : 2'b10;
      chk("lock_pop", 32'(bus.flit_pop_o), 32'(exp));
      tick();
      chk("lock_link_vc", 32'(bus.link_vc_o), 32'(exp));
      if (exp[0]) i0++;
    end
    chk("lock_credit", 32'(bus.credit_o), 32'(6'b010_000));
    chk("lock_err", 32'(bus.err_o), 32'(1'b0));
    bus.flit_valid_i = 2'b00;
`endif
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
